lrwait_qnode: RTL and testbench
===============================

// Module: lrwait_qnode
// PURPOSE
// Per-core LRWait queue node between a core's TCDM request/response port and the interconnect.
// - Absorbs successor updates from the bank (responses with meta.lrwait=1) and records the
//   successor's metadata.
// - After the core's SC completes, issues a wake-up LR (meta.lrwait=1, wdata=successor meta)
//   to the bank. The bank then makes the successor the queue head.
// - This is the core-side half of the hardware MCS queue whose tail lives at the bank.
// PARAMETERS
// AddrWidth  32  request address width
// DataWidth  32  data width; must be 32 and >= MetaWidth
// MetaWidth  16  flat metadata width; bit [MetaWidth-1] is the lrwait flag
// BeWidth    DataWidth/8  byte-enable width (derived, do not override)
// PORTS
// clk_i              in   1          clock
// rst_ni             in   1          asynchronous active-low reset
// core_req_valid_i   in   1          core request valid
// core_req_ready_o   out  1          core request ready
// core_req_addr_i    in   AddrWidth  request address
// core_req_amo_i     in   4          AMO opcode (0x0 none, 0xA LR, 0xB SC)
// core_req_write_i   in   1          1: store
// core_req_wdata_i   in   DataWidth  write data
// core_req_be_i      in   BeWidth    byte enable
// core_req_meta_i    in   MetaWidth  request metadata; lrwait bit always 0 from core
// core_resp_valid_o  out  1          response to core valid
// core_resp_ready_i  in   1          core accepts response
// core_resp_rdata_o  out  DataWidth  response data
// core_resp_meta_o   out  MetaWidth  response metadata
// net_req_*_o/_i     -    -          mirror of core_req_* toward interconnect (valid/ready/addr/amo/write/wdata/be/meta)
// net_resp_*_i/_o    -    -          mirror of core_resp_* from interconnect (valid/ready/rdata/meta)
// BEHAVIOUR
// - Reset: state=Idle, succ_valid=0, succ_meta=0, addr_q=0.
//   All valid outputs 0; net_resp_ready_o follows core_resp_ready_i.
// - Request path outside WakeUp: net_req_* = core_req_* and core_req_ready_o = net_req_ready_i.
//   Combinational, 0 added latency.
// - is_upd = net_resp_meta_i[MetaWidth-1].
//   - is_upd=0: core_resp_* = net_resp_* and net_resp_ready_o = core_resp_ready_i.
//   - is_upd=1: core_resp_valid_o=0, net_resp_ready_o=1. On valid: succ_meta <= net_resp_rdata_i[MetaWidth-1:0], succ_valid <= 1.
//   - Updates are accepted in every state. An update arriving while succ_valid=1 overwrites
//     succ_meta and fires an assertion error.
// - FSM (transitions on the handshake cycle):
//   - Idle: core LR handshake -> LRPend, addr_q <= addr.
//   - LRPend: non-update response handshake to core -> Rsvd.
//   - Rsvd, core SC handshake -> SCPend.
//   - Rsvd, core LR with addr == addr_q -> LRPend.
//   - Rsvd, core LR with addr != addr_q:
//     - succ_valid=1: core_req_ready_o=0 and net request suppressed; go to WakeUp, then Idle.
//       The LR is accepted afterwards.
//     - succ_valid=0: forward it, addr_q <= addr, go to LRPend.
//   - SCPend: non-update response handshake to core -> WakeUp if succ_valid (as updated that cycle), else Idle.
//   - WakeUp: core_req_ready_o=0. The qnode drives the net request:
//     - valid=1, addr=addr_q, amo=0xA, write=0, be=all ones
//     - wdata=zero-extended succ_meta
//     - meta={1'b1, (MetaWidth-1)'0}
//     On net handshake: succ_valid <= 0, go to Idle. Valid is held stable until ready.
// - Plain loads, stores and other AMOs pass through in all states except WakeUp.
//   They do not change state.
// - Interconnect must preserve per-bank response order. An update preceding the SC response is
//   therefore always captured before the SCPend exit decision.
// - Reset mid-operation clears the successor. The bank-side queue is also reset; no recovery
//   traffic is generated.
// TESTING
// - LR 0x100 with no queue: response rdata=0x5 -> core sees 0x5. SC -> core sees 0. No wake-up issued.
// - Update while in LRPend: meta=0x8000, rdata=0x0042 -> not forwarded; succ_meta=0x0042.
//   After the LR response and the SC response, exactly one net req is seen:
//   amo=0xA, addr=0x100, wdata=0x42, meta=0x8000.
// - Wake-up with net_req_ready_i low for 3 cycles -> request held stable.
//   core_req_ready_o=0 throughout. Idle after the handshake.
// - Rsvd with succ_valid, core LR to 0x200 -> wake-up to 0x100 first, then LR 0x200 forwarded.
// - Update and core_resp_ready_i=0 in same cycle -> update still consumed (net_resp_ready_o=1).
// - Reset asserted in SCPend with succ_valid=1 -> all valids 0, state Idle, no wake-up after release.

Source files
------------

// File: rtl/lrwait_qnode.sv
// lrwait_qnode: core-side LRWait queue node; tracks the successor and issues the wake-up LR after SC
module lrwait_qnode #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MetaWidth = 16,
    localparam int unsigned BeWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 core_req_valid_i,
    output logic                 core_req_ready_o,
    input  logic [AddrWidth-1:0] core_req_addr_i,
    input  logic [3:0]           core_req_amo_i,
    input  logic                 core_req_write_i,
    input  logic [DataWidth-1:0] core_req_wdata_i,
    input  logic [BeWidth-1:0]   core_req_be_i,
    input  logic [MetaWidth-1:0] core_req_meta_i,
    output logic                 core_resp_valid_o,
    input  logic                 core_resp_ready_i,
    output logic [DataWidth-1:0] core_resp_rdata_o,
    output logic [MetaWidth-1:0] core_resp_meta_o,
    output logic                 net_req_valid_o,
    input  logic                 net_req_ready_i,
    output logic [AddrWidth-1:0] net_req_addr_o,
    output logic [3:0]           net_req_amo_o,
    output logic                 net_req_write_o,
    output logic [DataWidth-1:0] net_req_wdata_o,
    output logic [BeWidth-1:0]   net_req_be_o,
    output logic [MetaWidth-1:0] net_req_meta_o,
    input  logic                 net_resp_valid_i,
    output logic                 net_resp_ready_o,
    input  logic [DataWidth-1:0] net_resp_rdata_i,
    input  logic [MetaWidth-1:0] net_resp_meta_i
);
    typedef enum logic [2:0] {Idle, LRPend, Rsvd, SCPend, WakeUp} state_e;
    state_e                 r_state, w_state_nxt;
    logic                   r_succ_valid, w_succ_valid_nxt;
    logic [MetaWidth-1:0]   r_succ_meta, w_succ_meta_nxt;
    logic [AddrWidth-1:0]   r_addr, w_addr_nxt;
    logic w_is_upd, w_upd, w_core_lr, w_core_sc, w_block, w_wake, w_core_hs, w_resp_hs;

    assign w_is_upd  = net_resp_meta_i[MetaWidth-1];
    assign w_upd     = net_resp_valid_i && w_is_upd;
    assign w_core_lr = core_req_amo_i == 4'hA;
    assign w_core_sc = core_req_amo_i == 4'hB;
    assign w_wake    = r_state == WakeUp;
    // A reservation switch to a new address must first hand the lock to the waiting successor
    assign w_block   = r_state == Rsvd && core_req_valid_i && w_core_lr &&
                       core_req_addr_i != r_addr && r_succ_valid;
    assign w_core_hs = core_req_valid_i && core_req_ready_o;
    assign w_resp_hs = net_resp_valid_i && !w_is_upd && core_resp_ready_i;

    assign core_resp_valid_o = net_resp_valid_i && !w_is_upd;
    assign core_resp_rdata_o = net_resp_rdata_i;
    assign core_resp_meta_o  = net_resp_meta_i;
    assign net_resp_ready_o  = w_is_upd || core_resp_ready_i;

    // Request mux: core passthrough, or the wake-up LR built from the recorded successor
    always_comb begin
        net_req_valid_o  = w_wake || (core_req_valid_i && !w_block);
        core_req_ready_o = !(w_wake || w_block) && net_req_ready_i;
        net_req_addr_o   = w_wake ? r_addr : core_req_addr_i;
        net_req_amo_o    = w_wake ? 4'hA : core_req_amo_i;
        net_req_write_o  = w_wake ? 1'b0 : core_req_write_i;
        net_req_wdata_o  = w_wake ? DataWidth'(r_succ_meta) : core_req_wdata_i;
        net_req_be_o     = w_wake ? '1 : core_req_be_i;
        net_req_meta_o   = w_wake ? {1'b1, {(MetaWidth-1){1'b0}}} : core_req_meta_i;
    end

    // Next-state logic; successor updates are absorbed in every state
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_succ_meta_nxt  = w_upd ? net_resp_rdata_i[MetaWidth-1:0] : r_succ_meta;
        w_succ_valid_nxt = w_upd || (r_succ_valid && !(w_wake && net_req_ready_i));
        case (r_state)
            Idle: if (w_core_hs && w_core_lr) begin
                w_state_nxt = LRPend;
                w_addr_nxt  = core_req_addr_i;
            end
            LRPend: if (w_resp_hs) w_state_nxt = Rsvd;
            Rsvd: if (w_block) w_state_nxt = WakeUp;
                else if (w_core_hs && w_core_lr) begin
                    w_state_nxt = LRPend;
                    w_addr_nxt  = core_req_addr_i;
                end else if (w_core_hs && w_core_sc) w_state_nxt = SCPend;
            SCPend: if (w_resp_hs) w_state_nxt = w_succ_valid_nxt ? WakeUp : Idle;
            WakeUp: if (net_req_ready_i) w_state_nxt = Idle;
            default: w_state_nxt = Idle;
        endcase
    end

    // State and successor registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= Idle;
            r_succ_valid <= 1'b0;
            r_succ_meta  <= '0;
            r_addr       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_succ_valid <= w_succ_valid_nxt;
            r_succ_meta  <= w_succ_meta_nxt;
            r_addr       <= w_addr_nxt;
        end
    end

    // A second successor update before the wake-up means the bank-side queue is inconsistent
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_upd && r_succ_valid))
        else $error("lrwait_qnode: successor update overwrote a pending successor");
endmodule

// File: tb/tb_lrwait_qnode.sv
// tb_lrwait_qnode: directed vectors for the LRWait queue node
module tb_lrwait_qnode;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_valid_i, core_req_ready_o;
    logic [31:0] core_req_addr_i;
    logic [3:0]  core_req_amo_i;
    logic        core_req_write_i;
    logic [31:0] core_req_wdata_i;
    logic [3:0]  core_req_be_i;
    logic [15:0] core_req_meta_i;
    logic        core_resp_valid_o, core_resp_ready_i;
    logic [31:0] core_resp_rdata_o;
    logic [15:0] core_resp_meta_o;
    logic        net_req_valid_o, net_req_ready_i;
    logic [31:0] net_req_addr_o;
    logic [3:0]  net_req_amo_o;
    logic        net_req_write_o;
    logic [31:0] net_req_wdata_o;
    logic [3:0]  net_req_be_o;
    logic [15:0] net_req_meta_o;
    logic        net_resp_valid_i, net_resp_ready_o;
    logic [31:0] net_resp_rdata_i;
    logic [15:0] net_resp_meta_i;
    int n_vec = 0;
    int n_err = 0;

    lrwait_qnode dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
        .core_req_addr_i(core_req_addr_i), .core_req_amo_i(core_req_amo_i),
        .core_req_write_i(core_req_write_i), .core_req_wdata_i(core_req_wdata_i),
        .core_req_be_i(core_req_be_i), .core_req_meta_i(core_req_meta_i),
        .core_resp_valid_o(core_resp_valid_o), .core_resp_ready_i(core_resp_ready_i),
        .core_resp_rdata_o(core_resp_rdata_o), .core_resp_meta_o(core_resp_meta_o),
        .net_req_valid_o(net_req_valid_o), .net_req_ready_i(net_req_ready_i),
        .net_req_addr_o(net_req_addr_o), .net_req_amo_o(net_req_amo_o),
        .net_req_write_o(net_req_write_o), .net_req_wdata_o(net_req_wdata_o),
        .net_req_be_o(net_req_be_o), .net_req_meta_o(net_req_meta_o),
        .net_resp_valid_i(net_resp_valid_i), .net_resp_ready_o(net_resp_ready_o),
        .net_resp_rdata_i(net_resp_rdata_i), .net_resp_meta_i(net_resp_meta_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] amo, input logic [31:0] addr);
        core_req_valid_i = 1'b1;
        core_req_amo_i   = amo;
        core_req_addr_i  = addr;
        core_req_write_i = 1'b0;
        core_req_wdata_i = 32'h0;
        core_req_be_i    = 4'hF;
        core_req_meta_i  = 16'h0;
    endtask

    task automatic idle_req();
        core_req_valid_i = 1'b0;
        core_req_amo_i   = 4'h0;
        core_req_addr_i  = 32'h0;
    endtask

    task automatic fwd_req(input string tag, input logic [3:0] amo, input logic [31:0] addr);
        drive_req(amo, addr);
        #1;
        chk({tag, ".valid"}, 32'(net_req_valid_o), 32'h1);
        chk({tag, ".addr"}, net_req_addr_o, addr);
        chk({tag, ".amo"}, 32'(net_req_amo_o), 32'(amo));
        chk({tag, ".ready"}, 32'(core_req_ready_o), 32'h1);
        tick();
        idle_req();
    endtask

    task automatic fwd_resp(input string tag, input logic [31:0] rdata, input logic upd);
        net_resp_valid_i = 1'b1;
        net_resp_rdata_i = rdata;
        net_resp_meta_i  = upd ? 16'h8000 : 16'h0;
        #1;
        chk({tag, ".core_valid"}, 32'(core_resp_valid_o), upd ? 32'h0 : 32'h1);
        chk({tag, ".net_ready"}, 32'(net_resp_ready_o), upd ? 32'h1 : 32'(core_resp_ready_i));
        if (!upd) chk({tag, ".rdata"}, core_resp_rdata_o, rdata);
        tick();
        net_resp_valid_i = 1'b0;
        net_resp_meta_i  = 16'h0;
    endtask

    task automatic wake_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        chk({tag, ".valid"}, 32'(net_req_valid_o), 32'h1);
        chk({tag, ".addr"}, net_req_addr_o, addr);
        chk({tag, ".amo"}, 32'(net_req_amo_o), 32'hA);
        chk({tag, ".wdata"}, net_req_wdata_o, wd);
        chk({tag, ".meta"}, 32'(net_req_meta_o), 32'h8000);
        chk({tag, ".write"}, 32'(net_req_write_o), 32'h0);
        chk({tag, ".be"}, 32'(net_req_be_o), 32'hF);
        chk({tag, ".core_ready"}, 32'(core_req_ready_o), 32'h0);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_req();
        core_req_write_i  = 1'b0;
        core_req_wdata_i  = 32'h0;
        core_req_be_i     = 4'h0;
        core_req_meta_i   = 16'h0;
        core_resp_ready_i = 1'b1;
        net_req_ready_i   = 1'b1;
        net_resp_valid_i  = 1'b0;
        net_resp_rdata_i  = 32'h0;
        net_resp_meta_i   = 16'h0;
        tick();
        tick();
        chk("rst.net_req_valid", 32'(net_req_valid_o), 32'h0);
        chk("rst.core_resp_valid", 32'(core_resp_valid_o), 32'h0);
        chk("rst.net_resp_ready1", 32'(net_resp_ready_o), 32'h1);
        core_resp_ready_i = 1'b0;
        #1;
        chk("rst.net_resp_ready0", 32'(net_resp_ready_o), 32'h0);
        core_resp_ready_i = 1'b1;
        rst_ni = 1'b1;
        tick();
        // store passthrough
        drive_req(4'h0, 32'h80);
        core_req_write_i = 1'b1;
        core_req_wdata_i = 32'hDEADBEEF;
        core_req_be_i    = 4'h3;
        core_req_meta_i  = 16'h0123;
        #1;
        chk("st.wdata", net_req_wdata_o, 32'hDEADBEEF);
        chk("st.be", 32'(net_req_be_o), 32'h3);
        chk("st.write", 32'(net_req_write_o), 32'h1);
        chk("st.meta", 32'(net_req_meta_o), 32'h0123);
        tick();
        idle_req();
        core_req_write_i = 1'b0;
        net_resp_meta_i  = 16'h0055;
        #1;
        chk("resp.meta", 32'(core_resp_meta_o), 32'h0055);
        net_resp_meta_i  = 16'h0;
        // LR/SC with no queue
        fwd_req("t1.lr", 4'hA, 32'h100);
        fwd_resp("t1.lr_resp", 32'h5, 1'b0);
        fwd_req("t1.sc", 4'hB, 32'h100);
        fwd_resp("t1.sc_resp", 32'h0, 1'b0);
        chk("t1.no_wake0", 32'(net_req_valid_o), 32'h0);
        tick();
        chk("t1.no_wake1", 32'(net_req_valid_o), 32'h0);
        // successor recorded, wake-up after SC with 3 stall cycles
        fwd_req("t2.lr", 4'hA, 32'h100);
        fwd_resp("t2.upd", 32'h0042, 1'b1);
        fwd_resp("t2.lr_resp", 32'h7, 1'b0);
        fwd_req("t2.sc", 4'hB, 32'h100);
        net_req_ready_i = 1'b0;
        fwd_resp("t2.sc_resp", 32'h0, 1'b0);
        drive_req(4'h0, 32'h300);
        for (int i = 0; i < 3; i++) begin
            #1;
            wake_chk($sformatf("t3.stall%0d", i), 32'h100, 32'h42);
            tick();
        end
        net_req_ready_i = 1'b1;
        #1;
        wake_chk("t3.hs", 32'h100, 32'h42);
        tick();
        chk("t3.idle_addr", net_req_addr_o, 32'h300);
        chk("t3.idle_amo", 32'(net_req_amo_o), 32'h0);
        chk("t3.idle_ready", 32'(core_req_ready_o), 32'h1);
        tick();
        idle_req();
        #1;
        chk("t3.once0", 32'(net_req_valid_o), 32'h0);
        tick();
        chk("t3.once1", 32'(net_req_valid_o), 32'h0);
        // reservation switch with a waiting successor; update while core not ready
        fwd_req("t4.lr", 4'hA, 32'h100);
        core_resp_ready_i = 1'b0;
        fwd_resp("t5.upd", 32'h0077, 1'b1);
        core_resp_ready_i = 1'b1;
        fwd_resp("t4.lr_resp", 32'h9, 1'b0);
        drive_req(4'hA, 32'h200);
        #1;
        chk("t4.blk_ready", 32'(core_req_ready_o), 32'h0);
        chk("t4.blk_valid", 32'(net_req_valid_o), 32'h0);
        tick();
        wake_chk("t4.wake", 32'h100, 32'h77);
        tick();
        chk("t4.lr2_valid", 32'(net_req_valid_o), 32'h1);
        chk("t4.lr2_addr", net_req_addr_o, 32'h200);
        chk("t4.lr2_amo", 32'(net_req_amo_o), 32'hA);
        chk("t4.lr2_ready", 32'(core_req_ready_o), 32'h1);
        tick();
        idle_req();
        fwd_resp("t4.lr2_resp", 32'h3, 1'b0);
        // reset while in SCPend with a successor pending
        fwd_resp("t6.upd", 32'h0011, 1'b1);
        fwd_req("t6.sc", 4'hB, 32'h200);
        rst_ni = 1'b0;
        #1;
        chk("t6.rst_net_valid", 32'(net_req_valid_o), 32'h0);
        chk("t6.rst_core_valid", 32'(core_resp_valid_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        fwd_resp("t6.stray_resp", 32'h0, 1'b0);
        chk("t6.no_wake0", 32'(net_req_valid_o), 32'h0);
        fwd_req("t6.lr", 4'hA, 32'h400);
        fwd_resp("t6.lr_resp", 32'h1, 1'b0);
        fwd_req("t6.lr_switch", 4'hA, 32'h500);
        fwd_resp("t6.lr_switch_resp", 32'h2, 1'b0);
        fwd_req("t6.sc2", 4'hB, 32'h500);
        fwd_resp("t6.sc2_resp", 32'h0, 1'b0);
        chk("t6.no_wake1", 32'(net_req_valid_o), 32'h0);
        tick();
        chk("t6.no_wake2", 32'(net_req_valid_o), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
